// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads imem at fetch_pc and queues {pc, instr} in a DEPTH-entry FIFO.
// Latency: a word fetched at edge N is presented on out_* in the cycle after edge N.
// Backpressure: out_ready=0 holds the head entry; fetching stalls once the buffer is full.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024,
  parameter int          DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  // Keeps addresses word-aligned and inside the memory; wrap at MEM_BYTES-4 falls out of the mask.
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & 32'hFFFF_FFFC;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   pc_buf_q    [DEPTH];
  logic [31:0]   pc_buf_d    [DEPTH];
  logic [31:0]   instr_buf_q [DEPTH];
  logic [31:0]   instr_buf_d [DEPTH];
  logic          push;
  logic          pop;

  // Next-state logic: a redirect flushes the buffer but still lets this cycle's pop complete.
  always_comb begin
    pop         = (count_q != '0) && out_ready;
    push        = fetch_en && !redirect_valid && ((count_q < DEPTH_C) || pop);
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pc_buf_d    = pc_buf_q;
    instr_buf_d = instr_buf_q;
    count_d     = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    if (push) begin
      pc_buf_d[tail_q]    = fetch_pc_q;
      instr_buf_d[tail_q] = imem_data;
      tail_d              = tail_q + 1'b1;
      fetch_pc_d          = (fetch_pc_q + 32'd4) & ADDR_MASK;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc & ADDR_MASK;
    end
  end

  // State registers, all cleared asynchronously so no output is ever X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      pc_buf_q    <= '{default: '0};
      instr_buf_q <= '{default: '0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      pc_buf_q    <= pc_buf_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  // Outputs are forced to zero whenever the buffer is empty.
  always_comb begin
    imem_addr = fetch_pc_q;
    out_count = count_q;
    out_valid = (count_q != '0);
    out_pc    = out_valid ? pc_buf_q[head_q]    : 32'h0;
    out_instr = out_valid ? instr_buf_q[head_q] : 32'h0;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam int          MEM_BYTES = 1024;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          AW        = $clog2(MEM_BYTES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [$clog2(DEPTH):0] out_count;

  logic [7:0] mem [MEM_BYTES];
  logic [AW-1:0] ia;

  int checks = 0;
  int errors = 0;

  ent_t        mdl_buf[$];
  ent_t        exp_q[$];
  logic [31:0] seen_pc[$];
  logic [31:0] seen_instr[$];
  logic [31:0] mdl_pc;
  int          exp_cnt;
  logic [31:0] exp_addr;
  logic        chk_vld = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] held_pc, held_instr;

  instruction_fetch #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian combinational instruction memory
  assign ia = imem_addr[AW-1:0];
  assign imem_data = {mem[ia + AW'(3)], mem[ia + AW'(2)], mem[ia + AW'(1)], mem[ia]};

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int i;
    i = int'(a % MEM_BYTES);
    return {mem[(i + 3) % MEM_BYTES], mem[(i + 2) % MEM_BYTES], mem[(i + 1) % MEM_BYTES], mem[i]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model advances as a queue of fetched words.
  task automatic cycle(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic do_pop, can_push;
    @(negedge clk);
    fetch_en = fe; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    exp_cnt  = mdl_buf.size();
    exp_addr = mdl_pc;
    do_pop   = (mdl_buf.size() > 0) && rdy;
    can_push = fe && !rv && ((mdl_buf.size() < DEPTH) || do_pop);
    if (do_pop) exp_q.push_back(mdl_buf.pop_front());
    if (rv) begin
      mdl_buf.delete();
      mdl_pc = (rpc % MEM_BYTES) & 32'hFFFF_FFFC;
    end else if (can_push) begin
      mdl_buf.push_back(ent_t'({mdl_pc, word_at(mdl_pc)}));
      mdl_pc = (mdl_pc + 32'd4) % MEM_BYTES;
    end
    chk_vld = 1'b1;
    #2;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    chk("pending_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_count", {29'b0, out_count}, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    mdl_buf.delete();
    exp_q.delete();
    mdl_pc = RESET_PC;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every presented/accepted output against the scoreboard
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) prev_stall = 1'b0;
      if (chk_vld) begin
        chk_vld = 1'b0;
        chk("out_count", {29'b0, out_count}, exp_cnt);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_cnt != 0});
        chk("imem_addr", imem_addr, exp_addr);
        if (!out_valid) begin
          chk("idle_out_pc", out_pc, 0);
          chk("idle_out_instr", out_instr, 0);
        end
        if (prev_stall) begin
          chk("stall_valid", {31'b0, out_valid}, 1);
          chk("stall_pc", out_pc, held_pc);
          chk("stall_instr", out_instr, held_instr);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual_pc=%h expected=none", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
          end
          seen_pc.push_back(out_pc);
          seen_instr.push_back(out_instr);
        end
        prev_stall = out_valid && !out_ready && !redirect_valid;
        held_pc    = out_pc;
        held_instr = out_instr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom());
    {mem[3], mem[2], mem[1], mem[0]} = 32'h2010_0006;
    {mem[7], mem[6], mem[5], mem[4]} = 32'h2011_0008;
    mdl_pc = RESET_PC;
    #3;
    chk("init_out_valid", {31'b0, out_valid}, 0);
    chk("init_out_count", {29'b0, out_count}, 0);
    chk("init_out_pc", out_pc, 0);
    chk("init_imem_addr", imem_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, then redirect to 0x2A while pc 4 is at the head
    b = seen_pc.size();
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 32'h2A);
    cycle(1, 1, 0, 0);
    chk("redirect_bubble", {31'b0, out_valid}, 0);
    cycle(1, 1, 0, 0);
    chk("stream_n", seen_pc.size(), b + 3);
    chk("stream_pc0", seen_pc[b], 32'h0);
    chk("stream_instr0", seen_instr[b], 32'h2010_0006);
    chk("stream_pc1", seen_pc[b + 1], 32'h4);
    chk("stream_instr1", seen_instr[b + 1], 32'h2011_0008);
    chk("redirect_pc", seen_pc[b + 2], 32'h28);

    // Wrap through the top of memory
    cycle(1, 1, 1, 32'h3FC);
    b = seen_pc.size();
    cycle(1, 1, 0, 0);
    chk("wrap_bubble", {31'b0, out_valid}, 0);
    repeat (3) cycle(1, 1, 0, 0);
    chk("wrap_n", seen_pc.size(), b + 3);
    chk("wrap_pc0", seen_pc[b], 32'h3FC);
    chk("wrap_pc1", seen_pc[b + 1], 32'h0);
    chk("wrap_pc2", seen_pc[b + 2], 32'h4);

    // Backpressure from reset
    do_reset();
    b = seen_pc.size();
    repeat (5) cycle(1, 0, 0, 0);
    chk("bp_count", {29'b0, out_count}, 2);
    chk("bp_imem_addr", imem_addr, 32'h8);
    chk("bp_head_pc", out_pc, 32'h0);
    chk("bp_head_instr", out_instr, 32'h2010_0006);
    repeat (3) cycle(1, 1, 0, 0);
    chk("bp_n", seen_pc.size(), b + 3);
    chk("bp_pc0", seen_pc[b], 32'h0);
    chk("bp_pc1", seen_pc[b + 1], 32'h4);
    chk("bp_pc2", seen_pc[b + 2], 32'h8);

    // fetch_en low drains a full buffer and holds the fetch address
    b = seen_pc.size();
    repeat (3) cycle(0, 1, 0, 0);
    chk("drain_n", seen_pc.size(), b + 2);
    chk("drain_valid", {31'b0, out_valid}, 0);
    chk("drain_imem_addr", imem_addr, 32'd20);

    // Reset with two entries buffered
    repeat (3) cycle(1, 0, 0, 0);
    chk("pre_reset_count", {29'b0, out_count}, 2);
    do_reset();
    b = seen_pc.size();
    repeat (3) cycle(1, 1, 0, 0);
    chk("post_reset_n", seen_pc.size(), b + 2);
    chk("post_reset_pc", seen_pc[b], RESET_PC);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) == 0), $urandom());
      end
    end
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
